// File: rtl/control_sequencer.sv
// control_sequencer
//
// Two-state instruction sequencer.
//
// FETCH phase
//   - Requests an instruction word from RAM.
//   - Latches the word into the instruction register when the RAM flags it valid.
//
// EXEC phase
//   - Forwards the control word of the selected decoder straight onto the
//     datapath control outputs.
//   - Steps the execute sub-state until the decoder returns next_state == 0.
//   - A watchdog bounds the number of consecutive EXEC cycles per instruction.
//
// Optional feature (macro CTRL_SEQ_PERF_EN)
//   Adds two free-running performance counters:
//   - retired_cnt : counts instructions that finish normally.
//   - cycle_cnt   : counts every non-reset cycle.
//
// Parameters
//   EXEC_LIMIT  maximum consecutive EXEC cycles per instruction (>= 1)
//
// Ports
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous, active-high
//   instr_in     instruction word from the RAM data bus
//   instr_valid  instr_in is valid this cycle (only looked at in FETCH)
//   cw_in        33-bit control word from the selected decoder
//   status_in    ALU status flags
//   ir_out       latched instruction register, feeds the decoders
//   state_out    execute sub-state, feeds the decoders
//   status_out   registered status flags
//   alu_en .. status_ld  datapath controls
//   fault        high during the EXEC cycle in which the watchdog expires
//   retired_cnt, cycle_cnt  performance counters (CTRL_SEQ_PERF_EN only)
module control_sequencer #(
  parameter int EXEC_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic [32:0] cw_in,
  input  logic [4:0]  status_in,
  output logic [31:0] ir_out,
  output logic [1:0]  state_out,
  output logic [4:0]  status_out,
  output logic        alu_en,
  output logic        alu_bs,
  output logic [4:0]  alu_fs,
  output logic        rf_b_en,
  output logic [4:0]  rf_sa,
  output logic [4:0]  rf_sb,
  output logic [4:0]  rf_da,
  output logic        rf_w,
  output logic        ram_en,
  output logic        ram_w,
  output logic        pc_en,
  output logic [1:0]  pc_fs,
  output logic        pc_is,
  output logic        status_ld,
  output logic        fault
`ifdef CTRL_SEQ_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt
`endif
);

  // FSM encoding kept as plain constants so older decoders and scripts that
  // peek at the state register keep working.
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_EXEC  = 1'b1;

  // Counter only needs to reach EXEC_LIMIT-1.
  localparam int CNT_W = (EXEC_LIMIT > 2) ? $clog2(EXEC_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_LIMIT - 1);

  // Field layout of the decoder control word, MSB first.
  typedef struct packed {
    logic       alu_en;
    logic       alu_bs;
    logic [4:0] alu_fs;
    logic       rf_b_en;
    logic [4:0] rf_sa;
    logic [4:0] rf_sb;
    logic [4:0] rf_da;
    logic       rf_w;
    logic       ram_en;
    logic       ram_w;
    logic       pc_en;
    logic [1:0] pc_fs;
    logic       pc_is;
    logic       status_ld;
    logic [1:0] next_state;
  } cw_t;

  cw_t             cw;
  logic [0:0]      state;
  logic [1:0]      sub_state;
  logic [CNT_W-1:0] exec_cnt;
  logic            in_exec;
  logic            exec_done;
  logic            watchdog;

  assign cw        = cw_t'(cw_in);
  assign in_exec   = (state == ST_EXEC);

  // Decoder says this instruction is finished.
  assign exec_done = in_exec && (cw.next_state == 2'd0);

  // Watchdog fires on the last allowed EXEC cycle only if the decoder still
  // wants to continue; a normal exit on that same cycle is not a fault.
  assign watchdog  = in_exec && (exec_cnt == CNT_LAST) && (cw.next_state != 2'd0);
  assign fault     = watchdog;

  // Datapath control mux: fixed idle/fetch pattern, or the decoder word.
  always_comb begin
    alu_en    = 1'b0;
    alu_bs    = 1'b0;
    alu_fs    = 5'b11111;
    rf_b_en   = 1'b0;
    rf_sa     = 5'd0;
    rf_sb     = 5'd31;
    rf_da     = 5'd0;
    rf_w      = 1'b0;
    ram_en    = 1'b1;
    ram_w     = 1'b0;
    pc_en     = 1'b0;
    pc_fs     = 2'b00;
    pc_is     = 1'b0;
    status_ld = 1'b0;
    state_out = 2'd0;
    if (in_exec) begin
      alu_en    = cw.alu_en;
      alu_bs    = cw.alu_bs;
      alu_fs    = cw.alu_fs;
      rf_b_en   = cw.rf_b_en;
      rf_sa     = cw.rf_sa;
      rf_sb     = cw.rf_sb;
      rf_da     = cw.rf_da;
      rf_w      = cw.rf_w;
      ram_en    = cw.ram_en;
      ram_w     = cw.ram_w;
      pc_en     = cw.pc_en;
      pc_fs     = cw.pc_fs;
      pc_is     = cw.pc_is;
      status_ld = cw.status_ld;
      state_out = sub_state;
    end
  end

  // State register, instruction register, sub-state and watchdog counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_FETCH;
      ir_out    <= 32'd0;
      sub_state <= 2'd0;
      exec_cnt  <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (instr_valid) begin
            ir_out    <= instr_in;
            sub_state <= 2'd0;
            exec_cnt  <= '0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // instr_valid is deliberately ignored here.
          if (exec_done || watchdog) begin
            state     <= ST_FETCH;
            sub_state <= 2'd0;
          end else begin
            sub_state <= cw.next_state;
            exec_cnt  <= exec_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  // Status flags load only under decoder control in EXEC, including on the
  // watchdog cycle, whose controls still take effect.
  always_ff @(posedge clock) begin
    if (reset) begin
      status_out <= 5'd0;
    end else if (in_exec && cw.status_ld) begin
      status_out <= status_in;
    end
  end

`ifdef CTRL_SEQ_PERF_EN
  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt   <= 32'd0;
      retired_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (exec_done) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
